// File: rtl/xbar_arb_pkg.sv
// Shared types and constants for the crossbar slave-side arbiters.
package xbar_arb_pkg;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } arb_state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Wide enough for any DATA_W in the fabric; users slice the low bits.
  localparam int                         TIMEOUT_RDATA_W = 256;
  localparam logic [TIMEOUT_RDATA_W-1:0] TIMEOUT_RDATA   = '1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after `last`, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W:0] cand;

  // Walk from the farthest offset down so the nearest requester is written last.
  always_comb begin
    cand  = '0;
    idx   = '0;
    valid = 1'b0;
    for (int off = N; off >= 1; off--) begin
      cand = {1'b0, last} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (req[cand[IDX_W-1:0]]) begin
        idx   = cand[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Round-robin arbiter sharing one crossbar slave port among MASTER_NUM masters,
// one outstanding transaction at a time, with a per-phase watchdog.
//
// state     | meaning
// ARB       | idle; pick next requester after last_grant
// WAIT_ACK  | s_req driven, waiting for slave acceptance
// WAIT_RESP | accepted, waiting for slave completion
// DONE      | m_resp pulse to grantee; gap before next arbitration
module xbar_slave_arbiter
  import xbar_arb_pkg::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [MASTER_NUM-1:0]               m_req,
  input  logic [MASTER_NUM-1:0]               m_cmd,
  input  logic [MASTER_NUM-1:0][ADDR_W-1:0]   m_addr,
  input  logic [MASTER_NUM-1:0][DATA_W-1:0]   m_wdata,
  output logic [MASTER_NUM-1:0]               m_ack,
  output logic [MASTER_NUM-1:0]               m_resp,
  output logic [DATA_W-1:0]                   m_rdata,
  output logic                                s_req,
  output logic                                s_cmd,
  output logic [ADDR_W-1:0]                   s_addr,
  output logic [DATA_W-1:0]                   s_wdata,
  input  logic                                s_ack,
  input  logic                                s_resp,
  input  logic [DATA_W-1:0]                   s_rdata,
  output logic [$clog2(MASTER_NUM)-1:0]       grant_id,
  output logic                                busy,
  output logic                                timeout_err
);

  localparam int          GW         = $clog2(MASTER_NUM);
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);

  arb_state_e    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] pick_idx;
  logic          pick_valid;
  logic [15:0]   wdog;

  rr_pick #(.N(MASTER_NUM)) u_pick (
    .req   (m_req),
    .last  (last_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= ARB;
      last_grant  <= GW'(MASTER_NUM - 1);
      grant_id    <= '0;
      wdog        <= '0;
      m_ack       <= '0;
      m_resp      <= '0;
      m_rdata     <= '0;
      s_req       <= 1'b0;
      s_cmd       <= CMD_READ;
      s_addr      <= '0;
      s_wdata     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      m_ack       <= '0;
      m_resp      <= '0;
      timeout_err <= 1'b0;
      case (state)
        ARB: begin
          if (pick_valid) begin
            grant_id <= pick_idx;
            s_req    <= 1'b1;
            s_cmd    <= m_cmd[pick_idx];
            s_addr   <= m_addr[pick_idx];
            s_wdata  <= m_wdata[pick_idx];
            wdog     <= '0;
            busy     <= 1'b1;
            state    <= WAIT_ACK;
          end else begin
            s_cmd   <= CMD_READ;
            s_addr  <= '0;
            s_wdata <= '0;
          end
        end
        WAIT_ACK: begin
          if (s_ack) begin
            s_req           <= 1'b0;
            m_ack[grant_id] <= 1'b1;
            if (s_resp) begin
              m_rdata          <= s_rdata;
              m_resp[grant_id] <= 1'b1;
              state            <= DONE;
            end else begin
              wdog  <= '0;
              state <= WAIT_RESP;
            end
          end else if (wdog == WDOG_LIMIT) begin
            // Never accepted: the master still gets its ack so it can drop m_req.
            s_req            <= 1'b0;
            m_ack[grant_id]  <= 1'b1;
            m_rdata          <= TIMEOUT_RDATA[DATA_W-1:0];
            m_resp[grant_id] <= 1'b1;
            timeout_err      <= 1'b1;
            state            <= DONE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        WAIT_RESP: begin
          if (s_resp) begin
            m_rdata          <= s_rdata;
            m_resp[grant_id] <= 1'b1;
            state            <= DONE;
          end else if (wdog == WDOG_LIMIT) begin
            s_req            <= 1'b0;
            m_rdata          <= TIMEOUT_RDATA[DATA_W-1:0];
            m_resp[grant_id] <= 1'b1;
            timeout_err      <= 1'b1;
            state            <= DONE;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        DONE: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: doc/xbar_slave_arbiter.md
# xbar_slave_arbiter

Round-robin arbiter that shares one crossbar slave port among `MASTER_NUM` requesting masters. It serialises transactions on the slave side (one outstanding at a time) and routes `ack`, `resp` and `rdata` back to the granted master. A watchdog terminates transactions the slave never completes. It sits between the per-master request ports and a single slave in the crossbar fabric.

## Interface
- `MASTER_NUM`, 4: number of requesting masters, 2..16.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: cycles allowed per wait phase, 1..65535.
- `aclk`  in  1  sole clock; all logic rises on posedge.
- `areset`  in  1  reset, synchronous, active-high.
- `m_req`  in  MASTER_NUM  per-master request level; held until that master sees `m_ack`.
- `m_cmd`  in  MASTER_NUM  per-master command: 0 = read, 1 = write.
- `m_addr`  in  MASTER_NUM×ADDR_W  per-master address.
- `m_wdata`  in  MASTER_NUM×DATA_W  per-master write data.
- `m_ack`  out  MASTER_NUM  one-cycle acceptance pulse to the granted master.
- `m_resp`  out  MASTER_NUM  one-cycle completion pulse to the granted master.
- `m_rdata`  out  DATA_W  shared read data; valid only with an `m_resp` bit.
- `s_req`, `s_cmd`, `s_addr`, `s_wdata`  out  1/1/ADDR_W/DATA_W  slave request; fields stable while `s_req`=1.
- `s_ack`  in  1  slave accepts the request.
- `s_resp`  in  1  slave completes; `s_rdata` valid.
- `s_rdata`  in  DATA_W  slave read data.
- `grant_id`  out  $clog2(MASTER_NUM)  current or last grantee.
- `busy`  out  1  high in any state other than ARB.
- `timeout_err`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- FSM states: ARB, WAIT_ACK, WAIT_RESP, DONE.
- ARB:
  - Masters are searched starting at `last_grant`+1 mod `MASTER_NUM`; the first one with `m_req` set wins.
  - On a win: register `grant_id`, latch `s_cmd`/`s_addr`/`s_wdata` from the winner, set `s_req`, go to WAIT_ACK.
  - With no requests, `s_cmd`/`s_addr`/`s_wdata` are driven to 0.
- WAIT_ACK:
  - `s_req` stays high.
  - On `s_ack`: clear `s_req`, pulse `m_ack[grant_id]`.
  - If `s_resp` is also set in that cycle, go to DONE; otherwise go to WAIT_RESP.
- WAIT_RESP: on `s_resp`, capture `s_rdata` into `m_rdata` and go to DONE.
- DONE:
  - `m_resp[grant_id]` is high for this one cycle.
  - `last_grant` ← `grant_id`.
  - Next state is ARB. The one-cycle gap guarantees the served master has dropped `m_req` before the next arbitration.
- Watchdog:
  - A 16-bit counter is cleared on entry to WAIT_ACK and on entry to WAIT_RESP, and increments in both states.
  - When the count reaches `TIMEOUT` without the awaited event:
    - clear `s_req`;
    - pulse `m_ack[grant_id]` if it was not yet given;
    - set `m_rdata` to all-ones;
    - pulse `timeout_err` and go to DONE.
- `s_ack`/`s_resp` arriving in ARB or DONE (including late responses after a timeout) are ignored.
- Reset values:
  - state ARB; `last_grant` = `MASTER_NUM`-1, so master 0 wins first;
  - `grant_id` 0, counter 0;
  - all outputs 0.
- Reset mid-transaction aborts it silently: no `m_ack`/`m_resp` is issued.

## Timing
- All outputs are registered.
- Request-to-slave latency:
  - `m_req` sampled in ARB at cycle t;
  - `s_req` high from t+1.
- `s_ack` sampled at cycle a → `m_ack` high at a+1 and `s_req` low at a+1.
- `s_resp` sampled at cycle r → `m_resp` and `m_rdata` valid at r+1, the DONE cycle; ARB at r+2.
- Minimum transaction with ack and resp in the same cycle: ARB t, WAIT_ACK t+1, DONE t+2, ARB t+3. Back-to-back grants are therefore spaced at 3 cycles or more.
- Timeout fires at the cycle where counter = `TIMEOUT`; `timeout_err`, `m_resp` and DONE follow at the next cycle.
- `m_ack` and `m_resp` may assert in the same cycle. A master must then drop `m_req` within one cycle of `m_ack`.

## Structure
- Package `xbar_arb_pkg`:
  - `arb_state_e` enum;
  - `CMD_READ`=0 and `CMD_WRITE`=1;
  - `TIMEOUT_RDATA` (all-ones) constant.
- Sub-module `rr_pick`: combinational round-robin selector taking the `m_req` vector and `last_grant`, returning winner index and `valid`. Reused by other crossbar arbiters.

## Test plan
- Single read: master 2 requests `addr`=0x40; slave acks 2 cycles later and resps 3 cycles after that with 0xDEADBEEF → `s_addr`=0x40, `s_cmd`=0; `m_ack[2]` pulses once; `m_resp[2]` pulses with `m_rdata`=0xDEADBEEF; ARB 2 cycles after `s_resp`.
- Fairness: all 4 masters hold `m_req` continuously and the slave acks and resps immediately → grant order 0,1,2,3,0,1; each transaction 3 cycles apart.
- Write then read from master 1, `wdata`=0x1234 → `s_cmd`=1 with `s_wdata`=0x1234 for the write, then `s_cmd`=0 with `s_wdata`=0.
- Timeout: `TIMEOUT`=8, slave acks but never resps → `timeout_err` pulses 9 cycles after WAIT_RESP entry; `m_resp` pulses with `m_rdata`=0xFFFFFFFF; a late `s_resp` in ARB is ignored.
- Reset: assert `areset` in WAIT_RESP for 1 cycle → all outputs 0, no `m_resp`; next request from master 3 (with master 0 also requesting) grants master 0.
- Simultaneous ack+resp: slave asserts `s_ack` and `s_resp` in the same cycle → `m_ack` and `m_resp` both pulse in the DONE cycle; the next grant is not issued to the same master.
